// File: rtl/data_memory_responder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_memory_responder_pkg: bus types and widths for the data RAM |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package data_memory_responder_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    ACCESS_BYTE = 2'd0,
    ACCESS_HALF = 2'd1,
    ACCESS_WORD = 2'd2
  } DataAccess;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ClearState;

endpackage
`default_nettype wire

// File: rtl/data_memory_bus_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | DataMemoryBus: core-to-data-memory bus with master/slave modports |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface DataMemoryBus;
  import data_memory_responder_pkg::*;

  logic [ADDR_WIDTH-1:0] addr;
  DataAccess             access;
  logic [DATA_WIDTH-1:0] wrData;
  logic                  wrEnable;
  logic [DATA_WIDTH-1:0] rdData;

  modport master (output addr, output access, output wrData, output wrEnable, input rdData);
  modport slave  (input addr, input access, input wrData, input wrEnable, output rdData);
endinterface
`default_nettype wire

// File: rtl/data_memory_responder_aligner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_lane_aligner: sub-word lane select/extend, write mask/shift  |
// | and alignment check. Revision: 1.0                               |
// +------------------------------------------------------------------+
module data_lane_aligner
  import data_memory_responder_pkg::*;
(
  input  DataAccess             i_access,
  input  logic [1:0]            i_lane,
  input  logic                  i_unsigned,
  input  logic [DATA_WIDTH-1:0] i_rd_word,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [3:0]            o_byte_mask,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_aligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v      = i_rd_word[{i_lane, 3'b000} +: 8];
    half_v      = i_rd_word[{i_lane[1], 4'b0000} +: 16];
    o_rd_data   = i_rd_word;
    o_byte_mask = 4'b1111;
    o_wr_data   = i_wr_data;
    o_aligned   = 1'b0;
    case (i_access)
      ACCESS_BYTE: begin
        o_rd_data   = {{24{~i_unsigned & byte_v[7]}}, byte_v};
        o_byte_mask = 4'b0001 << i_lane;
        o_wr_data   = i_wr_data << {i_lane, 3'b000};
        o_aligned   = 1'b1;
      end
      ACCESS_HALF: begin
        o_rd_data   = {{16{~i_unsigned & half_v[15]}}, half_v};
        o_byte_mask = 4'b0011 << i_lane;
        o_wr_data   = i_wr_data << {i_lane, 3'b000};
        o_aligned   = ~i_lane[0];
      end
      ACCESS_WORD: begin
        o_aligned   = (i_lane == 2'b00);
      end
      // Reserved encoding is reported as a bad access.
      default: o_aligned = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | data_memory_responder: data-bus slave RAM, sticky error record,   |
// | optional post-reset clear sweep (RV_DMEM_CLEAR_EN). Rev: 1.0     |
// +------------------------------------------------------------------+
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int                    DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE  = '0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  DataMemoryBus.slave           dataBus,
  input  logic                  i_unsigned,
  input  logic                  i_errClear,
  output logic                  o_ready,
  output logic                  o_error,
  output logic [ADDR_WIDTH-1:0] o_errAddr
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = IDX_W + 2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  hit;
  logic [IDX_W-1:0]      idx;
  logic                  aligned;
  logic                  good;
  logic                  bad;
  logic                  wr_go;
  logic                  ready;
  logic                  clr_we;
  logic [IDX_W-1:0]      clr_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_aligned;
  logic [3:0]            byte_mask;
  logic [DATA_WIDTH-1:0] wr_shifted;

  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  // BASE is aligned to the RAM size, so a hit is a match on the bits above the offset.
  assign hit     = (dataBus.addr >> OFF_W) == (BASE >> OFF_W);
  assign idx     = dataBus.addr[OFF_W-1:2];
  assign rd_word = mem_q[idx];
  assign good    = ready & hit & aligned;
  assign bad     = ready & ~(hit & aligned);
  assign wr_go   = good & dataBus.wrEnable;

  data_lane_aligner u_aligner (
    .i_access    (dataBus.access),
    .i_lane      (dataBus.addr[1:0]),
    .i_unsigned  (i_unsigned),
    .i_rd_word   (rd_word),
    .i_wr_data   (dataBus.wrData),
    .o_rd_data   (rd_aligned),
    .o_byte_mask (byte_mask),
    .o_wr_data   (wr_shifted),
    .o_aligned   (aligned)
  );

  assign dataBus.rdData = good ? rd_aligned : '0;

`ifdef RV_DMEM_CLEAR_EN
  ClearState        state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= CLEAR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    clr_we  = 1'b0;
    ready   = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (count_q == IDX_W'(DEPTH - 1)) state_d = RUN;
        else                              count_d = count_q + 1'b1;
      end
      RUN:     ready   = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  assign clr_idx = count_q;
`else
  assign ready   = 1'b1;
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
`endif

  always_ff @(posedge i_clock) begin
    if (clr_we) begin
      mem_q[clr_idx] <= '0;
    end else if (wr_go) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_mask[b]) mem_q[idx][8*b +: 8] <= wr_shifted[8*b +: 8];
      end
    end
  end

  // A new error in the same cycle as a clear wins and recaptures its address.
  always_comb begin
    error_d    = error_q;
    err_addr_d = err_addr_q;
    if (i_errClear) begin
      error_d    = 1'b0;
      err_addr_d = '0;
    end
    if (bad) begin
      error_d = 1'b1;
      if (!error_q || i_errClear) err_addr_d = dataBus.addr;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign o_ready   = ready;
  assign o_error   = error_q;
  assign o_errAddr = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_data_memory_responder: directed self-checking bench            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uns = 1'b0;
  logic        err_clr = 1'b0;
  logic        ready;
  logic        error;
  logic [31:0] err_addr;
  int          checks = 0;
  int          fails = 0;

  DataMemoryBus bus ();

  data_memory_responder #(.DEPTH(1024), .BASE(32'h0)) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .dataBus    (bus.slave),
    .i_unsigned (uns),
    .i_errClear (err_clr),
    .o_ready    (ready),
    .o_error    (error),
    .o_errAddr  (err_addr)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] a, input DataAccess acc, input logic [31:0] wd,
                       input logic we, input logic u, input logic clr);
    @(negedge clk);
    bus.addr     = a;
    bus.access   = acc;
    bus.wrData   = wd;
    bus.wrEnable = we;
    uns          = u;
    err_clr      = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(32'h0, ACCESS_WORD, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    int cnt;
    bus.addr = 32'h0; bus.access = ACCESS_WORD; bus.wrData = 32'h0; bus.wrEnable = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (err_addr !== 32'h0) begin fails++; $display("FAIL reset_errAddr: got %h want 0", err_addr); end
`ifdef RV_DMEM_CLEAR_EN
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", ready); end
`else
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready); end
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef RV_DMEM_CLEAR_EN
    cnt = 0;
    while (cnt < 2000) begin
      tick();
      cnt++;
      if (ready === 1'b1) break;
    end
    checks++; if (cnt != 1024) begin fails++; $display("FAIL sweep_length: got %0d edges want 1024", cnt); end
    drive(32'h3FC, ACCESS_WORD, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.rdData !== 32'h0) begin fails++; $display("FAIL sweep_zero_3FC: got %h want 0", bus.rdData); end
`else
    tick();
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b want 1", ready); end
`endif
  endtask

  task automatic test_sub_word();
    drive(32'h100, ACCESS_WORD, 32'h11223344, 1'b1, 1'b0, 1'b0); tick();
    drive(32'h101, ACCESS_BYTE, 32'h000000AA, 1'b1, 1'b0, 1'b0); tick();
    drive(32'h100, ACCESS_WORD, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.rdData !== 32'h1122AA44) begin fails++; $display("FAIL word_read_100: got %h want 1122aa44", bus.rdData); end
    drive(32'h101, ACCESS_BYTE, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.rdData !== 32'hFFFFFFAA) begin fails++; $display("FAIL byte_signed_101: got %h want ffffffaa", bus.rdData); end
    drive(32'h101, ACCESS_BYTE, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.rdData !== 32'h000000AA) begin fails++; $display("FAIL byte_unsigned_101: got %h want 000000aa", bus.rdData); end
    drive(32'h102, ACCESS_HALF, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.rdData !== 32'h00001122) begin fails++; $display("FAIL half_signed_102: got %h want 00001122", bus.rdData); end
    drive(32'h100, ACCESS_HALF, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.rdData !== 32'hFFFFAA44) begin fails++; $display("FAIL half_signed_100: got %h want ffffaa44", bus.rdData); end
    tick();
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL subword_no_error: got %b want 0", error); end
  endtask

  task automatic test_misaligned();
    drive(32'h102, ACCESS_WORD, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.rdData !== 32'h0) begin fails++; $display("FAIL misaligned_rd_zero: got %h want 0", bus.rdData); end
    tick();
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL misaligned_error: got %b want 1", error); end
    checks++; if (err_addr !== 32'h102) begin fails++; $display("FAIL misaligned_errAddr: got %h want 00000102", err_addr); end
    drive(32'h100, ACCESS_WORD, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.rdData !== 32'h1122AA44) begin fails++; $display("FAIL misaligned_ram_kept: got %h want 1122aa44", bus.rdData); end
    drive(32'h5001, ACCESS_BYTE, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    idle();
    checks++; if (err_addr !== 32'h102) begin fails++; $display("FAIL sticky_errAddr: got %h want 00000102", err_addr); end
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL sticky_error: got %b want 1", error); end
  endtask

  task automatic test_out_of_range();
    drive(32'h0, ACCESS_WORD, 32'h0, 1'b0, 1'b0, 1'b1); tick();
    idle();
    checks++; if (error !== 1'b0 || err_addr !== 32'h0) begin fails++; $display("FAIL clear: got %b/%h want 0/0", error, err_addr); end
    drive(32'h1000, ACCESS_WORD, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.rdData !== 32'h0) begin fails++; $display("FAIL oor_rd_zero: got %h want 0", bus.rdData); end
    tick();
    checks++; if (error !== 1'b1 || err_addr !== 32'h1000) begin fails++; $display("FAIL oor_error: got %b/%h want 1/00001000", error, err_addr); end
    drive(32'h7, ACCESS_HALF, 32'h0, 1'b0, 1'b0, 1'b1); tick();
    checks++; if (error !== 1'b1 || err_addr !== 32'h7) begin fails++; $display("FAIL clear_vs_new: got %b/%h want 1/00000007", error, err_addr); end
    drive(32'h0, ACCESS_WORD, 32'h0, 1'b0, 1'b0, 1'b1); tick();
    idle();
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL final_clear: got %b want 0", error); end
  endtask

  task automatic test_back_to_back();
    drive(32'h200, ACCESS_WORD, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0); tick();
    drive(32'h200, ACCESS_WORD, 32'h0BADBEEF, 1'b1, 1'b0, 1'b0);
    checks++; if (bus.rdData !== 32'hCAFEF00D) begin fails++; $display("FAIL rd_during_wr_old: got %h want cafef00d", bus.rdData); end
    tick();
    drive(32'h202, ACCESS_HALF, 32'h1234BEEF, 1'b1, 1'b0, 1'b0); tick();
    drive(32'h203, ACCESS_BYTE, 32'h00000012, 1'b1, 1'b0, 1'b0); tick();
    drive(32'h200, ACCESS_WORD, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.rdData !== 32'h12EFBEEF) begin fails++; $display("FAIL lane_merge_200: got %h want 12efbeef", bus.rdData); end
    drive(32'h202, ACCESS_HALF, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++; if (bus.rdData !== 32'h000012EF) begin fails++; $display("FAIL half_unsigned_202: got %h want 000012ef", bus.rdData); end
    idle();
  endtask

`ifdef RV_DMEM_CLEAR_EN
  task automatic test_reset_mid_sweep();
    int cnt;
    drive(32'h40, ACCESS_WORD, 32'h12345678, 1'b1, 1'b0, 1'b0); tick();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL midsweep_ready: got %b want 0", ready); end
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (cnt < 2000) begin
      tick();
      cnt++;
      if (ready === 1'b1) break;
      if (cnt == 800) begin
        bus.addr = 32'h40; bus.wrData = 32'hFFFFFFFF; bus.wrEnable = 1'b1;
      end else if (cnt == 801) begin
        bus.addr = 32'h0; bus.wrData = 32'h0; bus.wrEnable = 1'b0;
      end
    end
    checks++; if (cnt != 1024) begin fails++; $display("FAIL resweep_length: got %0d edges want 1024", cnt); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL sweep_write_no_error: got %b want 0", error); end
    drive(32'h40, ACCESS_WORD, 32'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.rdData !== 32'h0) begin fails++; $display("FAIL sweep_write_dropped: got %h want 0", bus.rdData); end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_sub_word();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
`ifdef RV_DMEM_CLEAR_EN
    test_reset_mid_sweep();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
